multi_lane_serializer: RTL and testbench

- Parametrised N:1 serializer, successor to the tree/shift mixed serializer.
- Runs on one clock with no derived clocks; per-bit pacing is counter based.
- Serializes LANES parallel words in lockstep, one bit per lane per cycle, with selectable bit order.
- A one-word holding buffer and valid/ready handshake give gapless back-to-back streaming; sits between the parallel datapath and the pad/output register stage.

---
 rtl/multi_lane_serializer.sv | 109 ++++++++++
 tb/tb_multi_lane_serializer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_lane_serializer.sv
// Lockstep N:1 serializer for LANES parallel words with a one-word holding buffer.
// A valid/ready handshake lets words stream back-to-back with no idle cycles.
module multi_lane_serializer #(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned LANES     = 1,
   parameter bit          MSB_FIRST = 1'b1,
   parameter logic        IDLE_VAL  = 1'b0
) (
   input  logic                    clk_i,
   input  logic                    reset_ni,
   input  logic [LANES*DATA_W-1:0] data_i,
   input  logic                    valid_i,
   output logic                    ready_o,
   output logic [LANES-1:0]        data_o,
   output logic                    frame_o,
   output logic                    busy_o
);

   localparam int unsigned      CNT_W   = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

   typedef enum logic {StIdle, StShift} state_e;

   state_e                       state_q, state_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic [LANES-1:0][DATA_W-1:0] sr_q, sr_d;
   logic [LANES*DATA_W-1:0]      hold_q, hold_d;
   logic                         hold_valid_q, hold_valid_d;
   logic                         last_bit;
   logic                         accept;
   logic [CNT_W-1:0]             bit_idx;

   // ready depends on registered state only, never on valid_i
   always_comb begin
      last_bit = (state_q == StShift) && (cnt_q == CNT_MAX);
      ready_o  = !hold_valid_q || last_bit;
      accept   = valid_i && ready_o;
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sr_d         = sr_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               sr_d    = data_i;
               cnt_d   = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            if (!last_bit) begin
               cnt_d = cnt_q + 1'b1;
               if (accept) begin
                  hold_d       = data_i;
                  hold_valid_d = 1'b1;
               end
            end else if (hold_valid_q) begin
               sr_d  = hold_q;
               cnt_d = '0;
               if (valid_i) begin
                  hold_d = data_i;
               end else begin
                  hold_valid_d = 1'b0;
               end
            end else if (accept) begin
               // Bypass the empty holding buffer so the stream stays gapless
               sr_d  = data_i;
               cnt_d = '0;
            end else begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         sr_q         <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sr_q         <= sr_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
      end
   end

   always_comb begin
      bit_idx = MSB_FIRST ? (CNT_MAX - cnt_q) : cnt_q;
      data_o  = {LANES{IDLE_VAL}};
      if (state_q == StShift) begin
         for (int unsigned l = 0; l < LANES; l++) begin
            data_o[l] = sr_q[l][bit_idx];
         end
      end
      frame_o = (state_q == StShift) && (cnt_q == '0);
      busy_o  = (state_q == StShift) || hold_valid_q;
   end

endmodule

// File: tb/tb_multi_lane_serializer.sv
// Bench for multi_lane_serializer: MSB-first and LSB-first instances share one stimulus,
// a bit-level scoreboard checks every cycle, and tables/sequences cover the corner cases.
module tb_multi_lane_serializer;

   logic        clk_i = 1'b0;
   logic        reset_ni;
   logic [15:0] data_i;
   logic        valid_i;
   logic        rdy_m, rdy_l, frm_m, frm_l, busy_m, busy_l;
   logic [1:0]  dm, dl;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [1:0] bit_m;
      logic [1:0] bit_l;
      logic       frame;
   } exp_t;

   exp_t sb_q[$];
   bit   exp_ready = 1'b1;

   typedef struct {
      logic [7:0] w0, w1, m0, m1, l0, l1;
   } vec_t;

   vec_t vt[4];

   always #5 clk_i = ~clk_i;

   multi_lane_serializer #(
      .DATA_W(8), .LANES(2), .MSB_FIRST(1'b1), .IDLE_VAL(1'b0)
   ) dut_m (
      .clk_i(clk_i), .reset_ni(reset_ni), .data_i(data_i), .valid_i(valid_i),
      .ready_o(rdy_m), .data_o(dm), .frame_o(frm_m), .busy_o(busy_m)
   );

   multi_lane_serializer #(
      .DATA_W(8), .LANES(2), .MSB_FIRST(1'b0), .IDLE_VAL(1'b0)
   ) dut_l (
      .clk_i(clk_i), .reset_ni(reset_ni), .data_i(data_i), .valid_i(valid_i),
      .ready_o(rdy_l), .data_o(dl), .frame_o(frm_l), .busy_o(busy_l)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: one entry per expected output cycle, pushed on accept, popped per edge
   always @(posedge clk_i or negedge reset_ni) begin
      exp_t e;
      if (!reset_ni) begin
         sb_q.delete();
      end else begin
         if (sb_q.size() > 0) void'(sb_q.pop_front());
         if (valid_i && exp_ready) begin
            for (int k = 0; k < 8; k++) begin
               e.bit_m = {data_i[8 + 7 - k], data_i[7 - k]};
               e.bit_l = {data_i[8 + k], data_i[k]};
               e.frame = (k == 0);
               sb_q.push_back(e);
            end
         end
      end
   end

   always @(negedge clk_i) begin
      exp_t e;
      int   qs;
      qs = sb_q.size();
      if (qs > 0) e = sb_q[0];
      else begin
         e.bit_m = 2'b00;
         e.bit_l = 2'b00;
         e.frame = 1'b0;
      end
      // Hold full means the current word plus one more complete word are pending
      exp_ready = (qs <= 8) || (qs % 8 == 1);
      check("sb data msb", dm, e.bit_m);
      check("sb data lsb", dl, e.bit_l);
      check("sb frame msb", frm_m, e.frame);
      check("sb frame lsb", frm_l, e.frame);
      check("sb ready msb", rdy_m, exp_ready);
      check("sb ready lsb", rdy_l, exp_ready);
      check("sb busy msb", busy_m, qs > 0);
      check("sb busy lsb", busy_l, qs > 0);
   end

   task automatic send(input logic [15:0] w, input bit keep_valid);
      bit acc;
      int n;
      data_i  = w;
      valid_i = 1'b1;
      n       = 0;
      do begin
         @(posedge clk_i);
         acc = exp_ready;
         n++;
      end while (!acc && n < 64);
      n_tests++;
      if (!acc) begin
         n_fail++;
         $display("FAIL send timeout: word %0h not accepted, expected acceptance", w);
      end
      #1;
      if (!keep_valid) valid_i = 1'b0;
   endtask

   // Aligns on the accept edge, then records n cycles of lane 0 / frame / ready (MSB instance)
   task automatic capture(input int n, output logic [31:0] dv, output logic [31:0] fv,
                          output logic [31:0] rv);
      dv = '0;
      fv = '0;
      rv = '0;
      @(posedge clk_i);
      for (int k = 0; k < n; k++) begin
         @(negedge clk_i);
         dv = {dv[30:0], dm[0]};
         fv = {fv[30:0], frm_m};
         rv = {rv[30:0], rdy_m};
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0]  cm0, cm1, cl0, cl1, fm, fl;
      logic [31:0] dv, fv, rv;

      vt[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
      vt[1] = '{8'h01, 8'h80, 8'h01, 8'h80, 8'h80, 8'h01};
      vt[2] = '{8'hF0, 8'h0F, 8'hF0, 8'h0F, 8'h0F, 8'hF0};
      vt[3] = '{8'h11, 8'h22, 8'h11, 8'h22, 8'h88, 8'h44};

      reset_ni = 1'b0;
      valid_i  = 1'b0;
      data_i   = '0;
      repeat (3) @(negedge clk_i);
      #1;
      check("reset data", {dl, dm}, 4'h0);
      check("reset frame", {frm_l, frm_m}, 2'b00);
      check("reset busy", {busy_l, busy_m}, 2'b00);
      @(negedge clk_i);
      #2 reset_ni = 1'b1;
      #1 check("ready after release", {rdy_l, rdy_m}, 2'b11);
      repeat (2) @(negedge clk_i);

      // Single words, both bit orders
      for (int i = 0; i < 4; i++) begin
         cm0 = '0; cm1 = '0; cl0 = '0; cl1 = '0; fm = '0; fl = '0;
         fork
            send({vt[i].w1, vt[i].w0}, 1'b0);
            begin
               @(posedge clk_i);
               for (int k = 0; k < 8; k++) begin
                  @(negedge clk_i);
                  cm0 = {cm0[6:0], dm[0]};
                  cm1 = {cm1[6:0], dm[1]};
                  cl0 = {cl0[6:0], dl[0]};
                  cl1 = {cl1[6:0], dl[1]};
                  fm  = {fm[6:0], frm_m};
                  fl  = {fl[6:0], frm_l};
               end
            end
         join
         check($sformatf("vec%0d msb lane0", i), cm0, vt[i].m0);
         check($sformatf("vec%0d msb lane1", i), cm1, vt[i].m1);
         check($sformatf("vec%0d lsb lane0", i), cl0, vt[i].l0);
         check($sformatf("vec%0d lsb lane1", i), cl1, vt[i].l1);
         check($sformatf("vec%0d frame", i), {fl, fm}, 16'h8080);
         @(negedge clk_i);
         check($sformatf("vec%0d idle after", i), {busy_l, busy_m}, 2'b00);
         @(negedge clk_i);
      end

      // Back-to-back streaming
      fork
         begin
            send({8'hEE, 8'h11}, 1'b1);
            send({8'hDD, 8'h22}, 1'b1);
            send({8'hCC, 8'h33}, 1'b0);
         end
         capture(24, dv, fv, rv);
      join
      check("b2b stream", dv, 32'h112233);
      check("b2b frame", fv, 32'h808080);
      check("b2b ready", rv, 32'h8101FF);
      repeat (3) @(negedge clk_i);

      // Backpressure: the word changed while ready is low must not be captured
      fork
         begin
            send({8'h00, 8'h5A}, 1'b1);
            send({8'h00, 8'hC3}, 1'b1);
            data_i = {8'h00, 8'hFF};
            repeat (3) @(posedge clk_i);
            #1;
            send({8'h00, 8'h96}, 1'b0);
         end
         capture(24, dv, fv, rv);
      join
      check("bp stream", dv, 32'h5AC396);
      check("bp ready", rv, 32'h8101FF);
      repeat (3) @(negedge clk_i);

      // Bypass on the last-bit cycle with the holding buffer empty
      fork
         begin
            send({8'h00, 8'hE7}, 1'b0);
            repeat (7) @(posedge clk_i);
            #1;
            send({8'h00, 8'h18}, 1'b0);
         end
         capture(16, dv, fv, rv);
      join
      check("bypass stream", dv, 32'hE718);
      check("bypass frame", fv, 32'h8080);
      check("bypass ready", rv, 32'hFFFF);
      repeat (3) @(negedge clk_i);

      // Reset mid-stream with a word in flight and one in hold
      data_i  = {8'h0F, 8'hF0};
      valid_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1 valid_i = 1'b0;
      @(negedge clk_i);
      #2 reset_ni = 1'b0;
      #1;
      check("midreset data", {dl, dm}, 4'h0);
      check("midreset frame", {frm_l, frm_m}, 2'b00);
      check("midreset busy", {busy_l, busy_m}, 2'b00);
      repeat (2) @(negedge clk_i);
      #3 reset_ni = 1'b1;
      #1 check("midreset ready", {rdy_l, rdy_m}, 2'b11);
      dv = '0;
      fv = '0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk_i);
         dv = {dv[29:0], dl, dm};
         fv = {fv[30:0], frm_m | frm_l};
      end
      check("no residual bits", dv, 32'h0);
      check("no residual frame", fv, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
